// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO/LIFO buffer family: mode encodings and the
// occupancy threshold compare used to build the almost_* flags.
package fifo_pkg;

  localparam logic MODE_FIFO = 1'b0;
  localparam logic MODE_LIFO = 1'b1;

  typedef enum logic [0:0] {
    CMP_GE = 1'b0,
    CMP_LE = 1'b1
  } cmp_dir_e;

  function automatic logic thresh_hit(input int unsigned cnt,
                                      input int unsigned thresh,
                                      input cmp_dir_e    dir);
    logic hit;
    case (dir)
      CMP_GE:  hit = (cnt >= thresh);
      CMP_LE:  hit = (cnt <= thresh);
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/fifo_lifo_mem.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// The read register is read-before-write, so a same-address write and read return the old word.
module fifo_lifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_r [0:(1 << ADDR_WIDTH)-1];

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port; holds its value when no read is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= {DATA_WIDTH{1'b0}};
    end else if (re) begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/syn_fifo_lifo.sv
// Single-clock buffer running as FIFO or LIFO stack, chosen while empty, with
// occupancy count, threshold flags, error pulses and a registered read strobe.
module syn_fifo_lifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int DEPTH         = 1 << ADDR_WIDTH,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic                  wr_cs,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_cs,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  mode_q
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   C_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] A_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH-1:0] rd_ptr_r;
  logic [ADDR_WIDTH:0]   count_r;
  logic                  mode_q_r;
  logic                  data_valid_r;
  logic                  overflow_r;
  logic                  underflow_r;

  logic                  wr_req_s;
  logic                  rd_req_s;
  logic                  empty_s;
  logic                  full_s;
  logic                  rd_acc_s;
  logic                  wr_acc_s;
  logic [ADDR_WIDTH-1:0] top_s;
  logic [ADDR_WIDTH-1:0] waddr_s;
  logic [ADDR_WIDTH-1:0] raddr_s;
  logic [ADDR_WIDTH:0]   count_nxt_s;

  assign wr_req_s = wr_cs & wr_en;
  assign rd_req_s = rd_cs & rd_en;
  assign empty_s  = (count_r == {(ADDR_WIDTH+1){1'b0}});
  assign full_s   = (count_r == DEPTH_C);
  // A full buffer still takes a write when a read frees the slot in the same cycle.
  assign rd_acc_s = rd_req_s & ~empty_s;
  assign wr_acc_s = wr_req_s & (~full_s | rd_acc_s);
  assign top_s    = count_r[ADDR_WIDTH-1:0] - A_ONE;

  // Next occupancy and memory addressing for the mode in effect.
  always_comb begin
    count_nxt_s = count_r;
    raddr_s     = rd_ptr_r;
    waddr_s     = wr_ptr_r;
    if (wr_acc_s && !rd_acc_s) begin
      count_nxt_s = count_r + C_ONE;
    end else if (rd_acc_s && !wr_acc_s) begin
      count_nxt_s = count_r - C_ONE;
    end else begin
      count_nxt_s = count_r;
    end
    // Stack mode: a simultaneous push replaces the word being popped.
    if (mode_q_r == MODE_LIFO) begin
      raddr_s = top_s;
      waddr_s = rd_acc_s ? top_s : count_r[ADDR_WIDTH-1:0];
    end else begin
      raddr_s = rd_ptr_r;
      waddr_s = wr_ptr_r;
    end
  end

  // Pointers, occupancy, mode latch and single-cycle status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r     <= {ADDR_WIDTH{1'b0}};
      rd_ptr_r     <= {ADDR_WIDTH{1'b0}};
      count_r      <= {(ADDR_WIDTH+1){1'b0}};
      mode_q_r     <= MODE_FIFO;
      data_valid_r <= 1'b0;
      overflow_r   <= 1'b0;
      underflow_r  <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      if (mode_q_r == MODE_FIFO) begin
        if (wr_acc_s) begin
          wr_ptr_r <= wr_ptr_r + A_ONE;
        end
        if (rd_acc_s) begin
          rd_ptr_r <= rd_ptr_r + A_ONE;
        end
      end
      if (empty_s && !wr_acc_s) begin
        mode_q_r <= mode;
      end
      data_valid_r <= rd_acc_s;
      overflow_r   <= wr_req_s & ~wr_acc_s;
      underflow_r  <= rd_req_s & empty_s;
    end
  end

  fifo_lifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc_s & ~rst),
    .waddr (waddr_s),
    .wdata (data_in),
    .re    (rd_acc_s & ~rst),
    .raddr (raddr_s),
    .rdata (data_out)
  );

  assign data_valid   = data_valid_r;
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;
  assign mode_q       = mode_q_r;
  assign count        = count_r;
  assign empty        = empty_s;
  assign full         = full_s;
  assign almost_empty = thresh_hit(32'(count_r), AEMPTY_THRESH, CMP_LE);
  assign almost_full  = thresh_hit(32'(count_r), AFULL_THRESH, CMP_GE);

endmodule

// File: tb/tb_syn_fifo_lifo.sv
// Bench for syn_fifo_lifo: directed vector table for the documented scenarios,
// then randomized traffic against a queue-based reference model.
module tb_syn_fifo_lifo;

  logic       clk = 1'b0;
  logic       rst, mode, wr_cs, wr_en, rd_cs, rd_en;
  logic [7:0] data_in, data_out;
  logic       data_valid, empty, full, almost_empty, almost_full;
  logic [2:0] count;
  logic       overflow, underflow, mode_q;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  syn_fifo_lifo #(
    .DATA_WIDTH(8), .ADDR_WIDTH(2), .DEPTH(4), .AFULL_THRESH(3), .AEMPTY_THRESH(1)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .wr_cs(wr_cs), .wr_en(wr_en),
    .data_in(data_in), .rd_cs(rd_cs), .rd_en(rd_en), .data_out(data_out),
    .data_valid(data_valid), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full), .count(count),
    .overflow(overflow), .underflow(underflow), .mode_q(mode_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, mode, wr, rd;
    logic [7:0] din;
    int         cnt;
    logic [7:0] dout;
    logic       dv, ov, ud, mq;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic m, logic w, logic rd, logic [7:0] d,
                              int c, logic [7:0] o, logic dv, logic ov, logic ud, logic mq);
    vec_t v;
    v.rst = r; v.mode = m; v.wr = w; v.rd = rd; v.din = d;
    v.cnt = c; v.dout = o; v.dv = dv; v.ov = ov; v.ud = ud; v.mq = mq;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  // Flags follow from occupancy with DEPTH=4, AFULL=3, AEMPTY=1.
  task automatic chk_all(input int c, input logic [7:0] o, input logic dv,
                         input logic ov, input logic ud, input logic mq);
    chk("count", int'(count), c);
    chk("empty", int'(empty), int'(c == 0));
    chk("full", int'(full), int'(c == 4));
    chk("almost_empty", int'(almost_empty), int'(c <= 1));
    chk("almost_full", int'(almost_full), int'(c >= 3));
    chk("data_out", int'(data_out), int'(o));
    chk("data_valid", int'(data_valid), int'(dv));
    chk("overflow", int'(overflow), int'(ov));
    chk("underflow", int'(underflow), int'(ud));
    chk("mode_q", int'(mode_q), int'(mq));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  logic [7:0] q[$];
  logic [7:0] m_dout;
  logic       m_dv, m_ov, m_ud, m_mq;

  initial begin
    rst = 1'b1; mode = 1'b0; wr_cs = 1'b0; wr_en = 1'b0;
    rd_cs = 1'b0; rd_en = 1'b0; data_in = 8'h00;

    //          rst   mode  wr    rd    din    cnt dout   dv    ov    ud    mq
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 8'hFF, 0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 8'hFF, 0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
    // FIFO order, full, overflow
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h11, 1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h22, 2, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h33, 3, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h44, 4, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h55, 4, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 3, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 2, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 0, 8'h44, 1'b1, 1'b0, 1'b0, 1'b0));
    // LIFO order and underflow
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 0, 8'h44, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 8'hA1, 1, 8'h44, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 8'hA2, 2, 8'h44, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 8'hA3, 3, 8'h44, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 2, 8'hA3, 1'b1, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1, 8'hA2, 1'b1, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 0, 8'hA1, 1'b1, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 0, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b1));
    // FIFO full with simultaneous read and write
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 8'hA1, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 1, 8'hA1, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h02, 2, 8'hA1, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h03, 3, 8'hA1, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h04, 4, 8'hA1, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 8'h99, 4, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 3, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 2, 8'h03, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 0, 8'h99, 1'b1, 1'b0, 1'b0, 1'b0));
    // LIFO simultaneous pop and push
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 0, 8'h99, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 8'h10, 1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 8'h20, 2, 8'h99, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 8'h30, 2, 8'h20, 1'b1, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1, 8'h30, 1'b1, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 0, 8'h10, 1'b1, 1'b0, 1'b0, 1'b1));
    // Deferred mode change
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h05, 1, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h06, 2, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1, 8'h05, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 0, 8'h06, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 0, 8'h06, 1'b0, 1'b0, 1'b0, 1'b1));
    // Mid-run reset
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 8'h07, 1, 8'h06, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 8'h08, 2, 8'h06, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 8'h09, 3, 8'h06, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
    // Simultaneous read and write while empty: no fall-through
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 0, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0));

    foreach (vecs[i]) begin
      rst = vecs[i].rst; mode = vecs[i].mode; data_in = vecs[i].din;
      wr_cs = vecs[i].wr; wr_en = vecs[i].wr;
      rd_cs = vecs[i].rd; rd_en = vecs[i].rd;
      step();
      chk_all(vecs[i].cnt, vecs[i].dout, vecs[i].dv, vecs[i].ov, vecs[i].ud, vecs[i].mq);
    end

    // Randomized traffic; the directed part leaves the buffer empty in FIFO mode with data_out=0x5A.
    m_dout = 8'h5A; m_mq = 1'b0;
    for (int i = 0; i < 800; i++) begin
      int  n;
      logic wreq, rreq, racc, wacc, op_lifo;
      bit   wr_heavy;
      wr_heavy = ((i / 40) % 2) == 0;
      rst   = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 5) == 0) mode = ~mode;
      wr_cs = ($urandom_range(0, 9) < (wr_heavy ? 8 : 4));
      wr_en = ($urandom_range(0, 7) != 0);
      rd_cs = ($urandom_range(0, 9) < (wr_heavy ? 4 : 8));
      rd_en = ($urandom_range(0, 7) != 0);
      data_in = 8'($urandom);
      wreq = wr_cs & wr_en;
      rreq = rd_cs & rd_en;
      if (rst) begin
        q.delete();
        m_dout = 8'h00; m_dv = 1'b0; m_ov = 1'b0; m_ud = 1'b0; m_mq = 1'b0;
      end else begin
        n       = q.size();
        op_lifo = m_mq;
        racc    = rreq && (n > 0);
        wacc    = wreq && ((n < 4) || racc);
        m_dv    = racc;
        m_ov    = wreq && !wacc;
        m_ud    = rreq && (n == 0);
        if (n == 0 && !wacc) m_mq = mode;
        if (racc) begin
          if (op_lifo) m_dout = q.pop_back();
          else         m_dout = q.pop_front();
        end
        if (wacc) q.push_back(data_in);
      end
      step();
      chk_all(q.size(), m_dout, m_dv, m_ov, m_ud, m_mq);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/syn_fifo_lifo.md
# syn_fifo_lifo

Parametrised single-clock buffer that operates as a FIFO or as a LIFO stack, selected at run time. It is the next-generation buffer for the LIFO_FIFO block set. It adds:
- a true full flag at DEPTH entries,
- programmable almost-full and almost-empty thresholds,
- an occupancy count,
- overflow and underflow error pulses,
- a registered read-data valid strobe.

It sits between a producer and a consumer in the same clock domain.

## Interface
- DATA_WIDTH, 8, data word width
- ADDR_WIDTH, 4, address width
- DEPTH, 1<<ADDR_WIDTH, entries; must equal 2**ADDR_WIDTH
- AFULL_THRESH, DEPTH-2, almost_full asserts when count >= this value
- AEMPTY_THRESH, 2, almost_empty asserts when count <= this value

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- mode  in  1  0 = FIFO, 1 = LIFO; sampled only while empty
- wr_cs  in  1  write chip select
- wr_en  in  1  write enable; write request = wr_cs & wr_en
- data_in  in  DATA_WIDTH  write data
- rd_cs  in  1  read chip select
- rd_en  in  1  read enable; read request = rd_cs & rd_en
- data_out  out  DATA_WIDTH  registered read data
- data_valid  out  1  one-cycle pulse; data_out updated this cycle
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_empty  out  1  count <= AEMPTY_THRESH
- almost_full  out  1  count >= AFULL_THRESH
- count  out  ADDR_WIDTH+1  occupancy, 0..DEPTH
- overflow  out  1  one-cycle pulse; write rejected
- underflow  out  1  one-cycle pulse; read rejected
- mode_q  out  1  mode currently in effect

## Operation
- **Reset:** while rst=1 at a clock edge:
  - pointers, count, data_out, data_valid, overflow, underflow and mode_q all go to 0;
  - outputs read empty=1, almost_empty=1, full=0, almost_full=0.
  - Reset mid-transfer discards all contents.
- **Mode:** mode_q <= mode on any edge where count==0 and no write is accepted. Otherwise mode_q holds, so a mode change while non-empty is deferred, not an error.
- **FIFO mode:** wr_ptr and rd_ptr each wrap modulo DEPTH.
  - Accepted write: mem[wr_ptr] <= data_in, wr_ptr++.
  - Accepted read: data_out <= mem[rd_ptr], rd_ptr++.
- **LIFO mode:** sp = count, the next free slot.
  - Push: mem[sp] <= data_in, count++.
  - Pop: data_out <= mem[sp-1], count--.
- **Rejection:**
  - Read when empty: rejected, underflow=1, data_out holds, data_valid=0.
  - Write when full: rejected and overflow=1, except in the simultaneous case below.
- **Simultaneous read and write, not empty:**
  - FIFO: both accepted and count unchanged, including when full.
  - LIFO: pop returns mem[sp-1], and data_in is written to mem[sp-1] (top replaced). count unchanged, including when full.
- **Simultaneous read and write when empty:** write accepted, read rejected with underflow=1. There is no fall-through path.
- **count arithmetic:** ADDR_WIDTH+1 bits and never wraps.
  - count+1 only on an accepted write without an accepted read.
  - count-1 only on an accepted read without an accepted write.

## Timing
- All outputs are registered or decoded from registers. There are no combinational paths from inputs to outputs.
- **Read latency:** 1 cycle. A request accepted at edge N gives data_out and data_valid=1 after edge N; data_valid is 0 on the following cycle unless another read is accepted.
- **Write visibility:** a write accepted at edge N is readable by a request presented for edge N+1.
- **Flags:** count, empty, full, almost_* and overflow/underflow update after the same edge as the triggering request.
- **Back-to-back throughput:** reads and writes sustain one per cycle each.

## Structure
- **Shared package fifo_pkg:**
  - MODE_FIFO=1'b0 and MODE_LIFO=1'b1 constants;
  - a function computing the threshold compare.
- **Sub-module fifo_lifo_mem:** simple dual-port synchronous RAM with one write port and one registered read port, parameters DATA_WIDTH and ADDR_WIDTH.
- **Top level:** pointer/stack-pointer control, count, flags and mode latch.

## Test plan
DATA_WIDTH=8, ADDR_WIDTH=2 (DEPTH=4), AFULL_THRESH=3, AEMPTY_THRESH=1.
- **Reset values:** assert rst for 2 cycles with wr_cs=wr_en=1.
  - Expect count=0, empty=1, almost_empty=1, full=0, data_out=0, no overflow.
- **FIFO order and full:** mode=0, write 0x11, 0x22, 0x33, 0x44, then 0x55.
  - Expect full=1 after the 4th write, and overflow pulse on the 5th write with count=4.
  - Then read 4 times: data_out = 0x11, 0x22, 0x33, 0x44, each with data_valid, then empty=1.
- **LIFO order and underflow:** mode=1 while empty, push 0xA1, 0xA2, 0xA3.
  - Pops return 0xA3, 0xA2, 0xA1.
  - A 4th pop gives underflow=1, data_out stays 0xA1, data_valid=0.
- **Simultaneous read and write in FIFO, full:** fill with 1..4, then read and write 0x99 together.
  - Expect data_out=1, count=4, no overflow.
  - Draining returns 2, 3, 4, 0x99.
- **Simultaneous pop and push in LIFO:** push 0x10, 0x20, then pop and push 0x30 together.
  - Expect data_out=0x20 and count=2.
  - Next pops return 0x30, then 0x10.
- **Deferred mode change and mid-run reset:**
  - Mode toggled while count=2: mode_q is unchanged, and changes on the cycle after the last read empties the buffer.
  - rst asserted while count=3: count=0 and empty=1 on the next cycle.
